// File: rtl/alarm_controller.sv
// alarm_controller
//   Holds a user-set alarm time and compares it against the live hr/min/sec
//   time-of-day. Runs the ring / snooze / dismiss state machine that drives
//   the buzzer.
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   tick                one-cycle strobe, live time shows a new second
//   hr, min, sec        live time of day
//   set_valid           strobe: load set_hr/set_min as the alarm time
//   set_hr, set_min     alarm time to load
//   arm_en              level: alarm enabled
//   snooze, dismiss     one-cycle UI strobes
//   alarm_hr, alarm_min stored alarm time
//   buzzer              high while ringing
//   state               0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZING
//   snooze_left         snoozes remaining for the current alarm event
//   set_err             one-cycle pulse on a rejected set request
module alarm_controller #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [4:0] hr,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       set_valid,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic       arm_en,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [4:0] alarm_hr,
    output logic [5:0] alarm_min,
    output logic       buzzer,
    output logic [1:0] state,
    output logic [1:0] snooze_left,
    output logic       set_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } state_t;

    localparam logic [15:0] RING_LIM = 16'(RING_SECS);
    localparam logic [15:0] SNZ_LOAD = 16'(SNOOZE_MIN * 60);
    localparam logic [1:0]  SNZ_MAX  = 2'(MAX_SNOOZE);

    // A requested alarm time is accepted only if it is a real time of day.
    function automatic logic time_valid(input logic [4:0] h, input logic [5:0] m);
        return (h <= 5'd23) && (m <= 6'd59);
    endfunction

    state_t      state_r, state_next_s;
    logic [1:0]  snooze_left_r, snooze_left_next_s;
    logic [15:0] ring_cnt_r, ring_cnt_next_s;
    logic [15:0] snz_cnt_r, snz_cnt_next_s;
    logic [4:0]  alarm_hr_r;
    logic [5:0]  alarm_min_r;
    logic        set_err_r;
    logic        match_s;

    // Alarm fires only at second zero, so one alarm time matches once per day.
    assign match_s = tick && (hr == alarm_hr_r) && (min == alarm_min_r) && (sec == 6'd0);

    // Alarm time storage and rejected-request pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_hr_r  <= 5'd0;
            alarm_min_r <= 6'd0;
            set_err_r   <= 1'b0;
        end else begin
            set_err_r <= set_valid && !time_valid(set_hr, set_min);
            if (set_valid && time_valid(set_hr, set_min)) begin
                alarm_hr_r  <= set_hr;
                alarm_min_r <= set_min;
            end
        end
    end

    // FSM state and its counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            snooze_left_r <= 2'd0;
            ring_cnt_r    <= 16'd0;
            snz_cnt_r     <= 16'd0;
        end else begin
            state_r       <= state_next_s;
            snooze_left_r <= snooze_left_next_s;
            ring_cnt_r    <= ring_cnt_next_s;
            snz_cnt_r     <= snz_cnt_next_s;
        end
    end

    // Next-state logic; disarming overrides every other input in every state.
    always_comb begin
        state_next_s       = state_r;
        snooze_left_next_s = snooze_left_r;
        ring_cnt_next_s    = ring_cnt_r;
        snz_cnt_next_s     = snz_cnt_r;
        if (!arm_en) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_ARMED;
                end
                ST_ARMED: begin
                    if (match_s) begin
                        state_next_s       = ST_RINGING;
                        snooze_left_next_s = SNZ_MAX;
                        ring_cnt_next_s    = 16'd0;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_RINGING: begin
                    if (dismiss) begin
                        state_next_s = ST_ARMED;
                    end else if (snooze && (snooze_left_r != 2'd0)) begin
                        state_next_s       = ST_SNOOZING;
                        snooze_left_next_s = snooze_left_r - 2'd1;
                        snz_cnt_next_s     = SNZ_LOAD;
                    end else if (tick) begin
                        // ring_cnt counts completed ticks; the RING_SECS-th tick times out.
                        if ((ring_cnt_r + 16'd1) == RING_LIM) begin
                            state_next_s = ST_ARMED;
                        end else begin
                            ring_cnt_next_s = ring_cnt_r + 16'd1;
                        end
                    end else begin
                        state_next_s = ST_RINGING;
                    end
                end
                ST_SNOOZING: begin
                    if (dismiss) begin
                        state_next_s = ST_ARMED;
                    end else if (tick) begin
                        if (snz_cnt_r == 16'd1) begin
                            state_next_s    = ST_RINGING;
                            ring_cnt_next_s = 16'd0;
                        end else begin
                            snz_cnt_next_s = snz_cnt_r - 16'd1;
                        end
                    end else begin
                        state_next_s = ST_SNOOZING;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    assign alarm_hr    = alarm_hr_r;
    assign alarm_min   = alarm_min_r;
    assign state       = state_r;
    assign buzzer      = (state_r == ST_RINGING);
    assign snooze_left = snooze_left_r;
    assign set_err     = set_err_r;

endmodule
